// File: rtl/pdp_pkg.sv
// Shared definitions for the multi-cycle datapath: FSM and ALU encodings,
// opcodes and instruction field positions.
package pdp_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALT   = 3'd5
   } state_e;

   typedef enum logic [2:0] {
      ALU_ADD  = 3'd0,
      ALU_SUB  = 3'd1,
      ALU_AND  = 3'd2,
      ALU_OR   = 3'd3,
      ALU_PASS = 3'd4
   } alu_op_e;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_ADDI = 4'h5;
   localparam logic [3:0] OP_LI   = 4'h6;
   localparam logic [3:0] OP_LW   = 4'h7;
   localparam logic [3:0] OP_SW   = 4'h8;
   localparam logic [3:0] OP_BEQ  = 4'h9;
   localparam logic [3:0] OP_BLT  = 4'hA;
   localparam logic [3:0] OP_J    = 4'hB;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam int INSTR_W = 16;
   localparam int OP_LSB  = 12;
   localparam int RS_LSB  = 10;
   localparam int RT_LSB  = 8;
   localparam int RD_LSB  = 6;
   localparam int IMM_W   = 8;

   function automatic logic [3:0] get_op(input logic [INSTR_W-1:0] instr);
      return instr[OP_LSB+3:OP_LSB];
   endfunction

   function automatic logic [1:0] get_rs(input logic [INSTR_W-1:0] instr);
      return instr[RS_LSB+1:RS_LSB];
   endfunction

   function automatic logic [1:0] get_rt(input logic [INSTR_W-1:0] instr);
      return instr[RT_LSB+1:RT_LSB];
   endfunction

   function automatic logic [1:0] get_rd(input logic [INSTR_W-1:0] instr);
      return instr[RD_LSB+1:RD_LSB];
   endfunction

   function automatic logic [IMM_W-1:0] get_imm(input logic [INSTR_W-1:0] instr);
      return instr[IMM_W-1:0];
   endfunction

endpackage

// File: rtl/pdp_alu.sv
// Combinational ALU: add/sub with signed-overflow detect, logic ops, pass-through,
// plus signed less-than and equality flags for branch resolution.
module pdp_alu
   import pdp_pkg::*;
#(
   parameter int DATA_W = 8
)(
   input  alu_op_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] y,
   output logic              ovf,
   output logic              lt,
   output logic              eq
);

   logic [DATA_W-1:0] sum_s;
   logic [DATA_W-1:0] diff_s;

   assign sum_s  = a + b;
   assign diff_s = a - b;

   // Result select; overflow is only meaningful for the add and subtract paths
   always_comb begin
      y   = {DATA_W{1'b0}};
      ovf = 1'b0;
      case (op)
         ALU_ADD: begin
            y   = sum_s;
            ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum_s[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_SUB: begin
            y   = diff_s;
            ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff_s[DATA_W-1] != a[DATA_W-1]);
         end
         ALU_AND:  y = a & b;
         ALU_OR:   y = a | b;
         ALU_PASS: y = b;
         default: begin
            y   = {DATA_W{1'b0}};
            ovf = 1'b0;
         end
      endcase
   end

   assign lt = ($signed(a) < $signed(b));
   assign eq = (a == b);

endmodule

// File: rtl/pdp_regfile.sv
// Two-read one-write register file; r0 always reads zero and ignores writes.
module pdp_regfile #(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [REG_AW-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [REG_AW-1:0] raddr_a,
   input  logic [REG_AW-1:0] raddr_b,
   output logic [DATA_W-1:0] rdata_a,
   output logic [DATA_W-1:0] rdata_b
);

   localparam int NREGS = 2 ** REG_AW;

   logic [DATA_W-1:0] regs_r [NREGS];

   // Register storage with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_r[i] <= {DATA_W{1'b0}};
         end
      end else if (we && (waddr != {REG_AW{1'b0}})) begin
         regs_r[waddr] <= wdata;
      end
   end

   // Read ports with r0 forced to zero
   always_comb begin
      if (raddr_a == {REG_AW{1'b0}}) begin
         rdata_a = {DATA_W{1'b0}};
      end else begin
         rdata_a = regs_r[raddr_a];
      end
      if (raddr_b == {REG_AW{1'b0}}) begin
         rdata_b = {DATA_W{1'b0}};
      end else begin
         rdata_b = regs_r[raddr_b];
      end
   end

endmodule

// File: rtl/pdatapath_mc.sv
// Multi-cycle datapath top: owns PC, IR and FSM (FETCH/DECODE/EXEC/MEM/WB/HALT),
// drives sync-read instruction and data memories and exposes retire/overflow status.
module pdatapath_mc
   import pdp_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_AW = 2,
   parameter int PC_W   = 8,
   parameter int CNT_W  = 16
)(
   input  logic              clk,
   input  logic              rst_general,
   input  logic              step_mode,
   input  logic              step,
   output logic [PC_W-1:0]   imem_addr,
   input  logic [15:0]       imem_rdata,
   output logic [DATA_W-1:0] dmem_addr,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic              dmem_we,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] wb_data,
   output logic              ovf_sticky,
   output logic              halted,
   output logic              illegal,
   output logic [CNT_W-1:0]  retired
);

   state_e            state_r;
   logic [15:0]       ir_r;
   logic [DATA_W-1:0] a_r;
   logic [DATA_W-1:0] b_r;
   logic [DATA_W-1:0] alu_r;

   logic [3:0]        op_s;
   logic [DATA_W-1:0] imm_d_s;
   logic [PC_W-1:0]   imm_p_s;
   logic [PC_W-1:0]   pc_inc_s;
   logic [PC_W-1:0]   br_tgt_s;

   alu_op_e           alu_op_s;
   logic [DATA_W-1:0] alu_b_s;
   logic [DATA_W-1:0] alu_y_s;
   logic              alu_ovf_s;
   logic              alu_lt_s;
   logic              alu_eq_s;
   logic              ovf_en_s;

   logic [REG_AW-1:0] rd_addr_a_s;
   logic [REG_AW-1:0] rd_addr_b_s;
   logic [DATA_W-1:0] rd_data_a_s;
   logic [DATA_W-1:0] rd_data_b_s;
   logic              wb_we_s;
   logic [REG_AW-1:0] wb_addr_s;
   logic [DATA_W-1:0] wb_val_s;

   assign op_s      = get_op(ir_r);
   assign imm_d_s   = DATA_W'($signed(get_imm(ir_r)));
   assign imm_p_s   = PC_W'($signed(get_imm(ir_r)));
   assign pc_inc_s  = pc + PC_W'(1);
   assign br_tgt_s  = pc_inc_s + imm_p_s;
   assign imem_addr = pc;

   // Register operands are read straight from the memory word while it is being latched
   assign rd_addr_a_s = REG_AW'(get_rs(imem_rdata));
   assign rd_addr_b_s = REG_AW'(get_rt(imem_rdata));
   assign wb_we_s     = (state_r == ST_WB);
   assign wb_val_s    = (op_s == OP_LW) ? dmem_rdata : alu_r;

   // Operand and operation select for the ALU in EXEC
   always_comb begin
      alu_op_s = ALU_ADD;
      alu_b_s  = b_r;
      ovf_en_s = 1'b0;
      case (op_s)
         OP_ADD:  ovf_en_s = 1'b1;
         OP_SUB: begin
            alu_op_s = ALU_SUB;
            ovf_en_s = 1'b1;
         end
         OP_AND:  alu_op_s = ALU_AND;
         OP_OR:   alu_op_s = ALU_OR;
         OP_ADDI: begin
            alu_b_s  = imm_d_s;
            ovf_en_s = 1'b1;
         end
         OP_LI: begin
            alu_op_s = ALU_PASS;
            alu_b_s  = imm_d_s;
         end
         OP_LW:   alu_b_s = imm_d_s;
         OP_SW:   alu_b_s = imm_d_s;
         default: begin
            alu_op_s = ALU_ADD;
            alu_b_s  = b_r;
            ovf_en_s = 1'b0;
         end
      endcase
   end

   // Register-register ops write rd; immediate ops and loads write rt
   always_comb begin
      wb_addr_s = REG_AW'(get_rt(ir_r));
      case (op_s)
         OP_ADD, OP_SUB, OP_AND, OP_OR: wb_addr_s = REG_AW'(get_rd(ir_r));
         default:                       wb_addr_s = REG_AW'(get_rt(ir_r));
      endcase
   end

   pdp_alu #(.DATA_W(DATA_W)) u_alu (
      .op  (alu_op_s),
      .a   (a_r),
      .b   (alu_b_s),
      .y   (alu_y_s),
      .ovf (alu_ovf_s),
      .lt  (alu_lt_s),
      .eq  (alu_eq_s)
   );

   pdp_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_general),
      .we      (wb_we_s),
      .waddr   (wb_addr_s),
      .wdata   (wb_val_s),
      .raddr_a (rd_addr_a_s),
      .raddr_b (rd_addr_b_s),
      .rdata_a (rd_data_a_s),
      .rdata_b (rd_data_b_s)
   );

   // Sequencer: each instruction retires (count + PC update) in its final state
   always_ff @(posedge clk or negedge rst_general) begin
      if (!rst_general) begin
         state_r    <= ST_FETCH;
         ir_r       <= 16'h0000;
         a_r        <= {DATA_W{1'b0}};
         b_r        <= {DATA_W{1'b0}};
         alu_r      <= {DATA_W{1'b0}};
         pc         <= {PC_W{1'b0}};
         dmem_addr  <= {DATA_W{1'b0}};
         dmem_wdata <= {DATA_W{1'b0}};
         dmem_we    <= 1'b0;
         wb_data    <= {DATA_W{1'b0}};
         ovf_sticky <= 1'b0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
         retired    <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_FETCH: begin
               if (!step_mode || step) begin
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               ir_r    <= imem_rdata;
               a_r     <= rd_data_a_s;
               b_r     <= rd_data_b_s;
               state_r <= ST_EXEC;
            end
            ST_EXEC: begin
               alu_r <= alu_y_s;
               case (op_s)
                  OP_NOP: begin
                     pc      <= pc_inc_s;
                     retired <= retired + CNT_W'(1);
                     state_r <= ST_FETCH;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LI: begin
                     if (ovf_en_s && alu_ovf_s) begin
                        ovf_sticky <= 1'b1;
                     end
                     state_r <= ST_WB;
                  end
                  OP_LW: begin
                     dmem_addr <= alu_y_s;
                     state_r   <= ST_MEM;
                  end
                  OP_SW: begin
                     dmem_addr  <= alu_y_s;
                     dmem_wdata <= b_r;
                     dmem_we    <= 1'b1;
                     state_r    <= ST_MEM;
                  end
                  OP_BEQ, OP_BLT: begin
                     if ((op_s == OP_BEQ) ? alu_eq_s : alu_lt_s) begin
                        pc <= br_tgt_s;
                     end else begin
                        pc <= pc_inc_s;
                     end
                     retired <= retired + CNT_W'(1);
                     state_r <= ST_FETCH;
                  end
                  OP_J: begin
                     pc      <= imm_p_s;
                     retired <= retired + CNT_W'(1);
                     state_r <= ST_FETCH;
                  end
                  OP_HALT: begin
                     halted  <= 1'b1;
                     retired <= retired + CNT_W'(1);
                     state_r <= ST_HALT;
                  end
                  default: begin
                     illegal <= 1'b1;
                     halted  <= 1'b1;
                     state_r <= ST_HALT;
                  end
               endcase
            end
            ST_MEM: begin
               dmem_we <= 1'b0;
               if (op_s == OP_SW) begin
                  pc      <= pc_inc_s;
                  retired <= retired + CNT_W'(1);
                  state_r <= ST_FETCH;
               end else begin
                  state_r <= ST_WB;
               end
            end
            ST_WB: begin
               wb_data <= wb_val_s;
               pc      <= pc_inc_s;
               retired <= retired + CNT_W'(1);
               state_r <= ST_FETCH;
            end
            ST_HALT: begin
               dmem_we <= 1'b0;
               state_r <= ST_HALT;
            end
            default: begin
               dmem_we <= 1'b0;
               state_r <= ST_FETCH;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pdatapath_mc.sv
// Directed self-checking bench for pdatapath_mc with behavioural sync-read memories.
module tb_pdatapath_mc;

   logic        clk = 1'b0;
   logic        rst_general = 1'b1;
   logic        step_mode = 1'b0;
   logic        step = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_rdata;
   logic [7:0]  dmem_addr;
   logic [7:0]  dmem_wdata;
   logic        dmem_we;
   logic [7:0]  dmem_rdata;
   logic [7:0]  pc;
   logic [7:0]  wb_data;
   logic        ovf_sticky;
   logic        halted;
   logic        illegal;
   logic [15:0] retired;

   logic [15:0] imem [256];
   logic [7:0]  dmem [256];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc;
   int we_cnt;
   logic [7:0] we_addr;
   logic [7:0] we_data;

   pdatapath_mc dut (
      .clk         (clk),
      .rst_general (rst_general),
      .step_mode   (step_mode),
      .step        (step),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .dmem_addr   (dmem_addr),
      .dmem_wdata  (dmem_wdata),
      .dmem_we     (dmem_we),
      .dmem_rdata  (dmem_rdata),
      .pc          (pc),
      .wb_data     (wb_data),
      .ovf_sticky  (ovf_sticky),
      .halted      (halted),
      .illegal     (illegal),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      imem_rdata <= imem[imem_addr];
      if (dmem_we) dmem[dmem_addr] <= dmem_wdata;
      dmem_rdata <= dmem[dmem_addr];
   end

   function automatic logic [15:0] ri(input logic [3:0] op, input logic [1:0] rs,
                                      input logic [1:0] rt, input logic [7:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [15:0] rr(input logic [3:0] op, input logic [1:0] rs,
                                      input logic [1:0] rt, input logic [1:0] rd);
      return {op, rs, rt, rd, 6'b000000};
   endfunction

   task automatic hold_reset();
      rst_general = 1'b0;
      step = 1'b0;
      step_mode = 1'b0;
      for (int i = 0; i < 256; i++) begin
         imem[i] = 16'hF000;
         dmem[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_general = 1'b1;
   endtask

   task automatic run_halt(input int max_cyc);
      cyc = 0; we_cnt = 0; we_addr = 8'h00; we_data = 8'h00;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk); #1;
         cyc++;
         if (dmem_we) begin
            we_cnt++; we_addr = dmem_addr; we_data = dmem_wdata;
         end
         if (halted) break;
      end
   endtask

   task automatic test_reset();
      hold_reset();
      #1;
      n_checks++; if (pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, 8'h00); end
      n_checks++; if (imem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_imem_addr: got %h want %h", imem_addr, 8'h00); end
      n_checks++; if (wb_data !== 8'h00) begin n_fail++; $display("FAIL reset_wb: got %h want %h", wb_data, 8'h00); end
      n_checks++; if (retired !== 16'd0) begin n_fail++; $display("FAIL reset_retired: got %0d want 0", retired); end
      n_checks++; if ({halted, illegal, ovf_sticky, dmem_we} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", {halted, illegal, ovf_sticky, dmem_we}); end
   endtask

   task automatic test_basic();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h05);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h03);
      imem[2] = rr(4'h1, 2'd1, 2'd2, 2'd3);
      imem[3] = 16'hF000;
      release_reset();
      run_halt(100);
      n_checks++; if (cyc !== 15) begin n_fail++; $display("FAIL basic_cycles: got %0d want 15", cyc); end
      n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted: got %b want 1", halted); end
      n_checks++; if (wb_data !== 8'h08) begin n_fail++; $display("FAIL basic_wb: got %h want %h", wb_data, 8'h08); end
      n_checks++; if (retired !== 16'd4) begin n_fail++; $display("FAIL basic_retired: got %0d want 4", retired); end
      n_checks++; if (pc !== 8'h03) begin n_fail++; $display("FAIL basic_pc: got %h want %h", pc, 8'h03); end
      n_checks++; if ({illegal, ovf_sticky} !== 2'b00) begin n_fail++; $display("FAIL basic_flags: got %b want 00", {illegal, ovf_sticky}); end
      repeat (10) @(negedge clk);
      n_checks++; if ({pc, retired, halted, dmem_we} !== {8'h03, 16'd4, 1'b1, 1'b0}) begin n_fail++; $display("FAIL halt_hold: pc %h retired %0d halted %b we %b want 03 4 1 0", pc, retired, halted, dmem_we); end
   endtask

   task automatic test_overflow();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h7F);
      imem[1] = ri(4'h5, 2'd1, 2'd1, 8'h01);
      imem[2] = ri(4'h6, 2'd0, 2'd2, 8'h01);
      imem[3] = rr(4'h1, 2'd2, 2'd2, 2'd3);
      release_reset();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (retired == 16'd2) break;
      end
      n_checks++; if (wb_data !== 8'h80) begin n_fail++; $display("FAIL addi_wrap: got %h want %h", wb_data, 8'h80); end
      n_checks++; if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL addi_ovf: got %b want 1", ovf_sticky); end
      run_halt(100);
      n_checks++; if ({wb_data, ovf_sticky} !== {8'h02, 1'b1}) begin n_fail++; $display("FAIL ovf_sticky_hold: wb %h ovf %b want 02 1", wb_data, ovf_sticky); end

      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h80);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h01);
      imem[2] = rr(4'h2, 2'd1, 2'd2, 2'd3);
      release_reset();
      run_halt(100);
      n_checks++; if ({wb_data, ovf_sticky} !== {8'h7F, 1'b1}) begin n_fail++; $display("FAIL sub_ovf: wb %h ovf %b want 7f 1", wb_data, ovf_sticky); end

      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'hC3);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h3C);
      imem[2] = rr(4'h4, 2'd1, 2'd2, 2'd3);
      imem[3] = rr(4'h3, 2'd3, 2'd1, 2'd3);
      release_reset();
      run_halt(100);
      n_checks++; if ({wb_data, ovf_sticky} !== {8'hC3, 1'b0}) begin n_fail++; $display("FAIL and_or: wb %h ovf %b want c3 0", wb_data, ovf_sticky); end
   endtask

   task automatic test_mem();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h10);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'hAB);
      imem[2] = ri(4'h8, 2'd1, 2'd2, 8'h00);
      imem[3] = ri(4'h7, 2'd1, 2'd3, 8'h00);
      release_reset();
      run_halt(100);
      n_checks++; if (we_cnt !== 1) begin n_fail++; $display("FAIL sw_we_cycles: got %0d want 1", we_cnt); end
      n_checks++; if ({we_addr, we_data} !== {8'h10, 8'hAB}) begin n_fail++; $display("FAIL sw_addr_data: got %h/%h want 10/ab", we_addr, we_data); end
      n_checks++; if (dmem[8'h10] !== 8'hAB) begin n_fail++; $display("FAIL sw_mem: got %h want ab", dmem[8'h10]); end
      n_checks++; if (wb_data !== 8'hAB) begin n_fail++; $display("FAIL lw_wb: got %h want ab", wb_data); end
      n_checks++; if ({retired, cyc} !== {16'd5, 32'd20}) begin n_fail++; $display("FAIL mem_timing: retired %0d cycles %0d want 5 20", retired, cyc); end
   endtask

   task automatic test_branch();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h03);
      imem[1] = ri(4'h5, 2'd1, 2'd1, 8'hFF);
      imem[2] = ri(4'h9, 2'd1, 2'd0, 8'h01);
      imem[3] = ri(4'hB, 2'd0, 2'd0, 8'h01);
      release_reset();
      run_halt(200);
      n_checks++; if ({halted, pc} !== {1'b1, 8'h04}) begin n_fail++; $display("FAIL loop_pc: halted %b pc %h want 1 04", halted, pc); end
      n_checks++; if (retired !== 16'd10) begin n_fail++; $display("FAIL loop_retired: got %0d want 10", retired); end
      n_checks++; if ({wb_data, cyc} !== {8'h00, 32'd34}) begin n_fail++; $display("FAIL loop_wb_cycles: wb %h cycles %0d want 00 34", wb_data, cyc); end

      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'hFE);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h01);
      imem[2] = ri(4'hA, 2'd1, 2'd2, 8'h01);
      imem[4] = ri(4'h6, 2'd0, 2'd3, 8'h66);
      release_reset();
      run_halt(100);
      n_checks++; if ({pc, wb_data, retired} !== {8'h05, 8'h66, 16'd5}) begin n_fail++; $display("FAIL blt_signed: pc %h wb %h retired %0d want 05 66 5", pc, wb_data, retired); end

      hold_reset();
      imem[0]   = ri(4'h9, 2'd1, 2'd0, 8'h01);
      imem[2]   = ri(4'h6, 2'd0, 2'd1, 8'h01);
      imem[3]   = ri(4'hB, 2'd0, 2'd0, 8'hFF);
      imem[255] = 16'h0000;
      release_reset();
      run_halt(100);
      n_checks++; if ({pc, retired, cyc} !== {8'h01, 16'd6, 32'd19}) begin n_fail++; $display("FAIL pc_wrap: pc %h retired %0d cycles %0d want 01 6 19", pc, retired, cyc); end
   endtask

   task automatic test_step();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h01);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h02);
      imem[2] = ri(4'h6, 2'd0, 2'd3, 8'h03);
      imem[3] = ri(4'h6, 2'd0, 2'd1, 8'h09);
      step_mode = 1'b1;
      release_reset();
      repeat (20) @(negedge clk);
      n_checks++; if ({retired, pc} !== {16'd0, 8'h00}) begin n_fail++; $display("FAIL step_stall: retired %0d pc %h want 0 00", retired, pc); end
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      @(negedge clk) step = 1'b1;
      @(negedge clk) step = 1'b0;
      repeat (18) @(negedge clk);
      n_checks++; if (retired !== 16'd1) begin n_fail++; $display("FAIL step_one: got %0d want 1", retired); end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk) step = 1'b1;
         @(negedge clk) step = 1'b0;
         repeat (20) @(negedge clk);
      end
      n_checks++; if ({retired, pc, wb_data, halted} !== {16'd3, 8'h03, 8'h03, 1'b0}) begin n_fail++; $display("FAIL step_three: retired %0d pc %h wb %h halted %b want 3 03 03 0", retired, pc, wb_data, halted); end
      step_mode = 1'b0;
      run_halt(100);
      n_checks++; if ({retired, wb_data, halted} !== {16'd5, 8'h09, 1'b1}) begin n_fail++; $display("FAIL step_resume: retired %0d wb %h halted %b want 5 09 1", retired, wb_data, halted); end
   endtask

   task automatic test_illegal();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h01);
      imem[1] = 16'h0000;
      imem[2] = 16'hD000;
      imem[3] = ri(4'h6, 2'd0, 2'd2, 8'h05);
      release_reset();
      run_halt(100);
      n_checks++; if ({illegal, halted} !== 2'b11) begin n_fail++; $display("FAIL illegal_flags: got %b want 11", {illegal, halted}); end
      n_checks++; if ({pc, wb_data} !== {8'h02, 8'h01}) begin n_fail++; $display("FAIL illegal_pc: pc %h wb %h want 02 01", pc, wb_data); end
   endtask

   task automatic test_reset_mid_sw();
      hold_reset();
      imem[0] = ri(4'h6, 2'd0, 2'd1, 8'h20);
      imem[1] = ri(4'h6, 2'd0, 2'd2, 8'h5A);
      imem[2] = ri(4'h8, 2'd1, 2'd2, 8'h00);
      release_reset();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (dmem_we) break;
      end
      n_checks++; if (dmem_we !== 1'b1) begin n_fail++; $display("FAIL midsw_reach: we %b want 1", dmem_we); end
      rst_general = 1'b0;
      #1;
      n_checks++; if ({dmem_we, pc, retired, wb_data} !== {1'b0, 8'h00, 16'd0, 8'h00}) begin n_fail++; $display("FAIL midsw_clear: we %b pc %h retired %0d wb %h want 0 00 0 00", dmem_we, pc, retired, wb_data); end
      @(posedge clk); #1;
      n_checks++; if (dmem[8'h20] !== 8'h00) begin n_fail++; $display("FAIL midsw_nostore: got %h want 00", dmem[8'h20]); end
      hold_reset();
      imem[0] = rr(4'h1, 2'd1, 2'd2, 2'd3);
      release_reset();
      run_halt(100);
      n_checks++; if ({wb_data, retired} !== {8'h00, 16'd2}) begin n_fail++; $display("FAIL midsw_regs: wb %h retired %0d want 00 2", wb_data, retired); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_mem();
      test_branch();
      test_step();
      test_illegal();
      test_reset_mid_sw();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
